sevenseg_scanner: RTL and testbench

SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

---
 rtl/sevenseg_scanner.sv | 125 ++++++++++++
 tb/tb_sevenseg_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// sevenseg_scanner
//
// Time-multiplexed driver for an 8-digit, common-anode seven-segment display
// with 16-step PWM brightness. Each digit owns a slot of 16 brightness phases.
// Each phase lasts TICKS_PER_PHASE clocks. A full frame is 8 slots. The data,
// the digit mask and the brightness are captured once per frame, so a frame is
// never drawn from a mix of old and new values.
//
// Ports
//   clock           : single clock
//   reset           : synchronous, active-high
//   sevenseg_data   : 8 bytes, digit i = [8i+7:8i], {dp,g,f,e,d,c,b,a}, 1 = lit
//   display_control : [0] enable, [11:4] digit mask, [19:16] brightness 0..15
//   anodes          : active-low digit selects, bit i = digit i (registered)
//   segments        : active-low cathodes, same order as data (registered)
//   frame_strobe    : one-cycle pulse in the cycle after each frame start
// -----------------------------------------------------------------------------
module sevenseg_scanner #(
    parameter int TICKS_PER_PHASE = 6250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] sevenseg_data,
    input  logic [31:0] display_control,
    output logic [7:0]  anodes,
    output logic [7:0]  segments,
    output logic        frame_strobe
);

    localparam int TICK_W = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_PHASE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        phase_q, phase_d;
    logic [2:0]        digit_q, digit_d;

    logic [63:0]       shadow_data_q, shadow_data_d;
    logic [7:0]        shadow_mask_q, shadow_mask_d;
    logic [3:0]        shadow_bright_q, shadow_bright_d;

    logic [7:0]        anodes_q, anodes_d;
    logic [7:0]        segments_q, segments_d;
    logic              strobe_q, strobe_d;

    logic              enable;
    logic              frame_start;
    logic              lit;

    assign enable      = display_control[0];
    assign frame_start = enable && (digit_q == 3'd0) && (phase_q == 4'd0)
                         && (tick_q == '0);

    always_comb begin
        tick_d          = tick_q;
        phase_d         = phase_q;
        digit_d         = digit_q;
        shadow_data_d   = shadow_data_q;
        shadow_mask_d   = shadow_mask_q;
        shadow_bright_d = shadow_bright_q;

        // Odometer: tick -> phase -> digit. Disabled means parked at zero, so
        // the first enabled cycle is always a frame start.
        if (!enable) begin
            tick_d  = '0;
            phase_d = 4'd0;
            digit_d = 3'd0;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (phase_q == 4'd15) begin
                phase_d = 4'd0;
                digit_d = digit_q + 3'd1;
            end else begin
                phase_d = phase_q + 4'd1;
            end
        end else begin
            tick_d = tick_q + TICK_ONE;
        end

        if (frame_start) begin
            shadow_data_d   = sevenseg_data;
            shadow_mask_d   = display_control[11:4];
            shadow_bright_d = display_control[19:16];
        end

        // Phase 0 is always dark to hide ghosting while the anode switches;
        // brightness b lights phases 1..b, so b = 0 never lights.
        lit = enable && (phase_q != 4'd0) && (phase_q <= shadow_bright_q)
              && shadow_mask_q[digit_q];

        anodes_d   = lit ? ~(8'h01 << digit_q) : 8'hFF;
        segments_d = lit ? ~shadow_data_q[{digit_q, 3'b000} +: 8] : 8'hFF;
        strobe_d   = frame_start;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q          <= '0;
            phase_q         <= 4'd0;
            digit_q         <= 3'd0;
            shadow_data_q   <= 64'd0;
            shadow_mask_q   <= 8'd0;
            shadow_bright_q <= 4'd0;
            anodes_q        <= 8'hFF;
            segments_q      <= 8'hFF;
            strobe_q        <= 1'b0;
        end else begin
            tick_q          <= tick_d;
            phase_q         <= phase_d;
            digit_q         <= digit_d;
            shadow_data_q   <= shadow_data_d;
            shadow_mask_q   <= shadow_mask_d;
            shadow_bright_q <= shadow_bright_d;
            anodes_q        <= anodes_d;
            segments_q      <= segments_d;
            strobe_q        <= strobe_d;
        end
    end

    assign anodes       = anodes_q;
    assign segments     = segments_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scanner
//
// Bench for sevenseg_scanner with TICKS_PER_PHASE = 2 (256-cycle frames).
// A reference model tracks the position inside the frame as one integer and
// derives digit/phase from it by division. Each cycle it pushes the expected
// registered outputs into a queue, and a monitor pops one entry per clock.
// Directed scenarios also check literal values at specific frame cycles.
// -----------------------------------------------------------------------------
module tb_sevenseg_scanner;

    localparam int T     = 2;
    localparam int FRAME = 128 * T;

    logic        clock;
    logic        reset;
    logic [63:0] sevenseg_data;
    logic [31:0] display_control;
    logic [7:0]  anodes;
    logic [7:0]  segments;
    logic        frame_strobe;

    sevenseg_scanner #(.TICKS_PER_PHASE(T)) dut (
        .clock          (clock),
        .reset          (reset),
        .sevenseg_data  (sevenseg_data),
        .display_control(display_control),
        .anodes         (anodes),
        .segments       (segments),
        .frame_strobe   (frame_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int          pos     = 0;
    logic [63:0] sh_data = 64'd0;
    logic [7:0]  sh_mask = 8'd0;
    logic [3:0]  sh_br   = 4'd0;

    task automatic model_step();
        exp_t e;
        int   dg;
        int   ph;
        e = '{an: 8'hFF, seg: 8'hFF, fs: 1'b0};
        if (reset) begin
            pos     = 0;
            sh_data = 64'd0;
            sh_mask = 8'd0;
            sh_br   = 4'd0;
        end else if (!display_control[0]) begin
            pos = 0;
        end else begin
            dg = pos / (16 * T);
            ph = (pos / T) % 16;
            if (ph >= 1 && ph <= int'(sh_br) && sh_mask[dg]) begin
                e.an  = ~(8'h01 << dg);
                e.seg = ~sh_data[dg*8 +: 8];
            end
            e.fs = (pos == 0);
            if (pos == 0) begin
                sh_data = sevenseg_data;
                sh_mask = display_control[11:4];
                sh_br   = display_control[19:16];
            end
            pos = (pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (anodes !== e.an || segments !== e.seg || frame_strobe !== e.fs) begin
                    miscompares++;
                    $display("FAIL model t=%0t: got an=%h seg=%h fs=%b, expected an=%h seg=%h fs=%b",
                             $time, anodes, segments, frame_strobe, e.an, e.seg, e.fs);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs for this cycle are in place: run the model, move to the next cycle.
    task automatic cyc();
        model_step();
        @(negedge clock);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                chk("reset_anodes", anodes, 8'hFF);
                chk("reset_segments", segments, 8'hFF);
                chk("reset_strobe", {7'd0, frame_strobe}, 8'h00);
            end
            cyc();
        end
        reset = 1'b0;
    endtask

    initial begin
        bit bad;
        int strobes;
        reset           = 1'b1;
        sevenseg_data   = 64'd0;
        display_control = 32'd0;
        @(negedge clock);

        // Full brightness, digit 0 = 0x3F
        sevenseg_data   = {$urandom, $urandom};
        sevenseg_data[7:0] = 8'h3F;
        display_control = 32'h000F0FF1;
        apply_reset(4);
        for (int k = 0; k < 260; k++) begin
            if (k == 0) chk("full_c0_blank", anodes, 8'hFF);
            if (k == 1) chk("full_c1_strobe", {7'd0, frame_strobe}, 8'h01);
            if (k == 1) chk("full_c1_blank", anodes, 8'hFF);
            if (k == 2) chk("full_c2_blank", anodes, 8'hFF);
            if (k == 2) chk("full_c2_nostrobe", {7'd0, frame_strobe}, 8'h00);
            if (k == 3) chk("full_c3_an", anodes, 8'hFE);
            if (k == 3) chk("full_c3_seg", segments, 8'hC0);
            if (k == 32) chk("full_c32_an", anodes, 8'hFE);
            if (k == 32) chk("full_c32_seg", segments, 8'hC0);
            if (k == 33) chk("full_c33_blank", anodes, 8'hFF);
            if (k == 34) chk("full_c34_blank", anodes, 8'hFF);
            if (k == 35) chk("full_c35_an", anodes, 8'hFD);
            cyc();
        end

        // Brightness 3
        display_control = 32'h00030FF1;
        apply_reset(3);
        bad = 1'b0;
        for (int k = 0; k < 42; k++) begin
            if (k == 3) chk("br3_c3_an", anodes, 8'hFE);
            if (k == 8) chk("br3_c8_an", anodes, 8'hFE);
            if (k >= 9 && k <= 34 && anodes !== 8'hFF) bad = 1'b1;
            if (k == 35) chk("br3_c35_an", anodes, 8'hFD);
            cyc();
        end
        chk("br3_blank_9_34", {7'd0, bad}, 8'h00);

        // No tearing: byte 0 changes mid-frame
        sevenseg_data[7:0] = 8'h3F;
        display_control    = 32'h000F0FF1;
        apply_reset(3);
        bad = 1'b0;
        for (int k = 0; k < 262; k++) begin
            if (k == 10) sevenseg_data[7:0] = 8'h06;
            if (k >= 3 && k <= 32 && segments !== 8'hC0) bad = 1'b1;
            if (k == 257) chk("tear_c257_strobe", {7'd0, frame_strobe}, 8'h01);
            if (k == 258) chk("tear_c258_seg", segments, 8'hFF);
            if (k == 259) chk("tear_c259_seg", segments, 8'hF9);
            if (k == 259) chk("tear_c259_an", anodes, 8'hFE);
            cyc();
        end
        chk("tear_frame0_seg", {7'd0, bad}, 8'h00);

        // Digit mask 0xFB: digit 2 skipped, period unchanged
        display_control = 32'h000F0FB1;
        apply_reset(3);
        bad     = 1'b0;
        strobes = 0;
        for (int k = 0; k < 520; k++) begin
            if (anodes[2] === 1'b0) bad = 1'b1;
            if (frame_strobe === 1'b1) strobes++;
            if (k == 99) chk("mask_c99_an", anodes, 8'hF7);
            if (k == 98) chk("mask_c98_blank", anodes, 8'hFF);
            if (k == 257) chk("mask_c257_strobe", {7'd0, frame_strobe}, 8'h01);
            if (k == 513) chk("mask_c513_strobe", {7'd0, frame_strobe}, 8'h01);
            cyc();
        end
        chk("mask_digit2_dark", {7'd0, bad}, 8'h00);
        chk("mask_strobe_count", 8'(strobes), 8'd3);

        // Enable drop and re-enable
        display_control = 32'h000F0FF1;
        apply_reset(3);
        for (int k = 0; k < 130; k++) begin
            if (k == 100) display_control[0] = 1'b0;
            if (k == 120) display_control[0] = 1'b1;
            if (k == 100) chk("en_c100_lit", anodes, 8'hF7);
            if (k == 101) chk("en_c101_an", anodes, 8'hFF);
            if (k == 110) chk("en_c110_seg", segments, 8'hFF);
            if (k == 110) chk("en_c110_strobe", {7'd0, frame_strobe}, 8'h00);
            if (k == 121) chk("en_c121_strobe", {7'd0, frame_strobe}, 8'h01);
            if (k == 122) chk("en_c122_blank", anodes, 8'hFF);
            if (k == 123) chk("en_c123_an", anodes, 8'hFE);
            cyc();
        end

        // Randomized traffic: mid-frame data/control changes, enable drops, resets
        sevenseg_data   = {$urandom, $urandom};
        display_control = $urandom;
        display_control[0] = 1'b1;
        apply_reset(2);
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(15) == 0) sevenseg_data = {$urandom, $urandom};
            if ($urandom_range(63) == 0)
                display_control = {$urandom} & 32'hFFFF_FFFE | {31'd0, display_control[0]};
            if ($urandom_range(299) == 0) display_control[0] = ~display_control[0];
            if (!display_control[0] && $urandom_range(19) == 0) display_control[0] = 1'b1;
            reset = ($urandom_range(599) == 0);
            cyc();
        end
        reset = 1'b0;

        repeat (2) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
